// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: control and hazard unit for a 5-stage RV32I/RV32E pipeline.
// Decodes D-stage fields, tracks E/M/W control state, and drives forwarding
// selects, stage holds, PC redirect and data-memory/write-back controls.
// The RV32M_EN macro builds the multi-cycle divide sequencer and the
// inst[25] (f7_0) decode. Without it, E_mdu_start is tied low and the
// divide freeze never asserts.
//
// Divide sequencer states:
//   S_IDLE | no divide running; a divide arriving in E launches one
//   S_RUN  | divide in progress; E frozen until the counter reaches 0
module pipe_hazard_ctrl #(
    parameter int RF_AW      = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       D_opcode,
    input  logic [2:0]       D_func3,
    input  logic             D_func7,
    input  logic             D_func7_0,
    input  logic [RF_AW-1:0] D_rd,
    input  logic [RF_AW-1:0] D_rs1,
    input  logic [RF_AW-1:0] D_rs2,
    input  logic             E_alu_bit0,
    input  logic             im_ready,
    input  logic             dm_ready,
    output logic             next_pc_sel,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_rs1_sel,
    output logic             D_rs2_sel,
    output logic [1:0]       E_rs1_sel,
    output logic [1:0]       E_rs2_sel,
    output logic             E_jb_op1_sel,
    output logic             E_alu_op1_sel,
    output logic             E_alu_op2_sel,
    output logic [4:0]       E_op,
    output logic [2:0]       E_f3,
    output logic             E_f7,
    output logic             E_mdu_start,
    output logic             M_dm_req,
    output logic [3:0]       M_dm_w_en,
    output logic             W_wb_en,
    output logic [RF_AW-1:0] W_rd,
    output logic [2:0]       W_f3,
    output logic             W_wb_data_sel
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_NOP    = OPC_OPIMM;

    function automatic logic uses_rs1(input logic [4:0] op);
        return op inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
    endfunction

    function automatic logic uses_rs2(input logic [4:0] op);
        return op inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    endfunction

    function automatic logic writes_rd(input logic [4:0] op);
        return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP};
    endfunction

    logic [4:0]       r_E_op;
    logic [2:0]       r_E_f3;
    logic             r_E_f7;
    logic             r_E_f7_0;
    logic [RF_AW-1:0] r_E_rd;
    logic [RF_AW-1:0] r_E_rs1;
    logic [RF_AW-1:0] r_E_rs2;
    logic [4:0]       r_M_op;
    logic [2:0]       r_M_f3;
    logic [RF_AW-1:0] r_M_rd;
    logic [4:0]       r_W_op;
    logic [2:0]       r_W_f3;
    logic [RF_AW-1:0] r_W_rd;

    logic w_dm_wait;
    logic w_div_frz;
    logic w_flush;
    logic w_load_use;
    logic w_im_wait;
    logic w_M_wr;
    logic w_W_wr;

    // Hazard sources. A redirect only takes effect when E is actually moving on.
    assign w_dm_wait  = M_dm_req & ~dm_ready;
    assign w_flush    = ~w_dm_wait & ~w_div_frz &
                        ((r_E_op == OPC_JAL) | (r_E_op == OPC_JALR) |
                         ((r_E_op == OPC_BRANCH) & E_alu_bit0));
    assign w_load_use = (r_E_op == OPC_LOAD) & (r_E_rd != '0) &
                        ((uses_rs1(D_opcode) & (D_rs1 == r_E_rd)) |
                         (uses_rs2(D_opcode) & (D_rs2 == r_E_rd)));
    assign w_im_wait  = ~im_ready;

    assign next_pc_sel = ~w_flush;
    assign F_stall     = w_dm_wait | w_div_frz | (~w_flush & (w_load_use | w_im_wait));
    assign D_stall     = F_stall;

    // Forwarding: E prefers the younger M result, then W; D only sees W.
    assign w_M_wr = writes_rd(r_M_op);
    assign w_W_wr = writes_rd(r_W_op);

    assign E_rs1_sel = (!uses_rs1(r_E_op) || r_E_rs1 == '0)  ? 2'd2 :
                       (w_M_wr && r_M_rd == r_E_rs1)         ? 2'd1 :
                       (w_W_wr && r_W_rd == r_E_rs1)         ? 2'd0 : 2'd2;
    assign E_rs2_sel = (!uses_rs2(r_E_op) || r_E_rs2 == '0)  ? 2'd2 :
                       (w_M_wr && r_M_rd == r_E_rs2)         ? 2'd1 :
                       (w_W_wr && r_W_rd == r_E_rs2)         ? 2'd0 : 2'd2;
    assign D_rs1_sel = uses_rs1(D_opcode) && D_rs1 != '0 && w_W_wr && r_W_rd == D_rs1;
    assign D_rs2_sel = uses_rs2(D_opcode) && D_rs2 != '0 && w_W_wr && r_W_rd == D_rs2;

    // Datapath operand selects: jump base is PC except for JALR; ALU op1 is PC
    // for AUIPC/JAL/JALR; ALU op2 is the immediate except for OP and BRANCH.
    assign E_jb_op1_sel  = (r_E_op != OPC_JALR);
    assign E_alu_op1_sel = (r_E_op == OPC_AUIPC) | (r_E_op == OPC_JAL) | (r_E_op == OPC_JALR);
    assign E_alu_op2_sel = ~((r_E_op == OPC_OP) | (r_E_op == OPC_BRANCH));
    assign E_op = r_E_op;
    assign E_f3 = r_E_f3;
    assign E_f7 = r_E_f7;

    // Byte enables follow f3 size; dm_ready does not gate them.
    assign M_dm_req  = (r_M_op == OPC_LOAD) | (r_M_op == OPC_STORE);
    assign M_dm_w_en = (r_M_op == OPC_STORE) ?
                       {r_M_f3[1], r_M_f3[1], r_M_f3[1] | r_M_f3[0], 1'b1} : 4'b0000;

    assign W_wb_en       = w_W_wr & (r_W_rd != '0);
    assign W_rd          = r_W_rd;
    assign W_f3          = r_W_f3;
    assign W_wb_data_sel = (r_W_op == OPC_LOAD);

    // E stage register: held by memory wait or divide, bubbled by redirect/stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_E_op   <= OPC_NOP;
            r_E_f3   <= '0;
            r_E_f7   <= 1'b0;
            r_E_f7_0 <= 1'b0;
            r_E_rd   <= '0;
            r_E_rs1  <= '0;
            r_E_rs2  <= '0;
        end else if (w_dm_wait || w_div_frz) begin
            r_E_op   <= r_E_op;
        end else if (w_flush || w_load_use || w_im_wait) begin
            r_E_op   <= OPC_NOP;
            r_E_f3   <= '0;
            r_E_f7   <= 1'b0;
            r_E_f7_0 <= 1'b0;
            r_E_rd   <= '0;
            r_E_rs1  <= '0;
            r_E_rs2  <= '0;
        end else begin
            r_E_op   <= D_opcode;
            r_E_f3   <= D_func3;
            r_E_f7   <= D_func7;
            r_E_f7_0 <= D_func7_0;
            r_E_rd   <= D_rd;
            r_E_rs1  <= D_rs1;
            r_E_rs2  <= D_rs2;
        end
    end

    // M stage register: held by memory wait, bubbled while a divide freezes E.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_M_op <= OPC_NOP;
            r_M_f3 <= '0;
            r_M_rd <= '0;
        end else if (w_dm_wait) begin
            r_M_op <= r_M_op;
        end else if (w_div_frz) begin
            r_M_op <= OPC_NOP;
            r_M_f3 <= '0;
            r_M_rd <= '0;
        end else begin
            r_M_op <= r_E_op;
            r_M_f3 <= r_E_f3;
            r_M_rd <= r_E_rd;
        end
    end

    // W stage register: a bubble enters while M waits on data memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_W_op <= OPC_NOP;
            r_W_f3 <= '0;
            r_W_rd <= '0;
        end else if (w_dm_wait) begin
            r_W_op <= OPC_NOP;
            r_W_f3 <= '0;
            r_W_rd <= '0;
        end else begin
            r_W_op <= r_M_op;
            r_W_f3 <= r_M_f3;
            r_W_rd <= r_M_rd;
        end
    end

`ifdef RV32M_EN
    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

    typedef enum logic {S_IDLE, S_RUN} div_state_t;

    div_state_t       r_div_state;
    div_state_t       w_div_state_nx;
    logic [CNT_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] w_div_cnt_nx;
    logic             w_is_div;

    assign w_is_div = (r_E_op == OPC_OP) & r_E_f7_0 & r_E_f3[2];

    // Sequencer state and residency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_state <= S_IDLE;
            r_div_cnt   <= '0;
        end else begin
            r_div_state <= w_div_state_nx;
            r_div_cnt   <= w_div_cnt_nx;
        end
    end

    // Launch on entry to E, freeze until count expires, release once E advances.
    always_comb begin
        w_div_state_nx = r_div_state;
        w_div_cnt_nx   = r_div_cnt;
        E_mdu_start    = 1'b0;
        w_div_frz      = 1'b0;
        case (r_div_state)
            S_IDLE: begin
                if (w_is_div) begin
                    E_mdu_start    = 1'b1;
                    w_div_frz      = 1'b1;
                    w_div_cnt_nx   = CNT_LOAD;
                    w_div_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (r_div_cnt != '0) begin
                    w_div_cnt_nx = r_div_cnt - CNT_W'(1);
                    w_div_frz    = 1'b1;
                end else if (!w_dm_wait) begin
                    w_div_state_nx = S_IDLE;
                end
            end
            default: w_div_state_nx = S_IDLE;
        endcase
    end
`else
    logic w_unused_f7_0;

    assign E_mdu_start   = 1'b0;
    assign w_div_frz     = 1'b0;
    assign w_unused_f7_0 = r_E_f7_0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle table for forwarding and
// load-use, followed by hand sequences for memory wait, redirect and divide.
module tb_pipe_hazard_ctrl;

    localparam logic [4:0] L_LOAD  = 5'b00000;
    localparam logic [4:0] L_STORE = 5'b01000;
    localparam logic [4:0] L_BR    = 5'b11000;
    localparam logic [4:0] L_JAL   = 5'b11011;
    localparam logic [4:0] L_OPI   = 5'b00100;
    localparam logic [4:0] L_OP    = 5'b01100;
    localparam logic [4:0] L_NOP   = 5'b00100;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] D_opcode;
    logic [2:0] D_func3;
    logic       D_func7, D_func7_0;
    logic [4:0] D_rd, D_rs1, D_rs2;
    logic       E_alu_bit0, im_ready, dm_ready;
    logic       next_pc_sel, F_stall, D_stall, D_rs1_sel, D_rs2_sel;
    logic [1:0] E_rs1_sel, E_rs2_sel;
    logic       E_jb_op1_sel, E_alu_op1_sel, E_alu_op2_sel;
    logic [4:0] E_op;
    logic [2:0] E_f3;
    logic       E_f7, E_mdu_start, M_dm_req;
    logic [3:0] M_dm_w_en;
    logic       W_wb_en;
    logic [4:0] W_rd;
    logic [2:0] W_f3;
    logic       W_wb_data_sel;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(.RF_AW(5), .DIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .D_opcode(D_opcode), .D_func3(D_func3), .D_func7(D_func7), .D_func7_0(D_func7_0),
        .D_rd(D_rd), .D_rs1(D_rs1), .D_rs2(D_rs2),
        .E_alu_bit0(E_alu_bit0), .im_ready(im_ready), .dm_ready(dm_ready),
        .next_pc_sel(next_pc_sel), .F_stall(F_stall), .D_stall(D_stall),
        .D_rs1_sel(D_rs1_sel), .D_rs2_sel(D_rs2_sel),
        .E_rs1_sel(E_rs1_sel), .E_rs2_sel(E_rs2_sel),
        .E_jb_op1_sel(E_jb_op1_sel), .E_alu_op1_sel(E_alu_op1_sel), .E_alu_op2_sel(E_alu_op2_sel),
        .E_op(E_op), .E_f3(E_f3), .E_f7(E_f7), .E_mdu_start(E_mdu_start),
        .M_dm_req(M_dm_req), .M_dm_w_en(M_dm_w_en),
        .W_wb_en(W_wb_en), .W_rd(W_rd), .W_f3(W_f3), .W_wb_data_sel(W_wb_data_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       x_fst;
        logic       x_npc;
        logic [4:0] x_eop;
        logic [1:0] x_s1;
        logic [1:0] x_s2;
        logic       x_wb;
        logic       x_req;
        logic       x_drs1;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                         input logic f70, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2);
        D_opcode  = op;
        D_func3   = f3;
        D_func7   = f7;
        D_func7_0 = f70;
        D_rd      = rd;
        D_rs1     = rs1;
        D_rs2     = rs2;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        //            op      f3      f7    rd     rs1    rs2    fst   npc   eop     s1    s2    wb    req   drs1
        tbl[0] = '{L_LOAD, 3'b010, 1'b0, 5'd5,  5'd2,  5'd0,  1'b0, 1'b1, L_NOP,  2'd2, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{L_OP,   3'b000, 1'b0, 5'd6,  5'd5,  5'd1,  1'b1, 1'b1, L_LOAD, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{L_OP,   3'b000, 1'b0, 5'd6,  5'd5,  5'd1,  1'b0, 1'b1, L_NOP,  2'd2, 2'd2, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{L_OP,   3'b000, 1'b1, 5'd6,  5'd5,  5'd5,  1'b0, 1'b1, L_OP,   2'd0, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{L_OP,   3'b000, 1'b0, 5'd7,  5'd0,  5'd6,  1'b0, 1'b1, L_OP,   2'd2, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{L_OP,   3'b000, 1'b0, 5'd9,  5'd7,  5'd0,  1'b0, 1'b1, L_OP,   2'd2, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{L_OP,   3'b000, 1'b0, 5'd0,  5'd9,  5'd9,  1'b0, 1'b1, L_OP,   2'd1, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{L_OP,   3'b000, 1'b0, 5'd10, 5'd0,  5'd0,  1'b0, 1'b1, L_OP,   2'd1, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{L_OPI,  3'b000, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, L_OP,   2'd2, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{L_OPI,  3'b000, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, L_NOP,  2'd2, 2'd2, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        set_d(L_NOP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        E_alu_bit0 = 1'b0;
        im_ready   = 1'b1;
        dm_ready   = 1'b1;

        #12;
        chk("rst next_pc_sel", next_pc_sel, 1);
        chk("rst F_stall", F_stall, 0);
        chk("rst D_stall", D_stall, 0);
        chk("rst E_op", E_op, L_NOP);
        chk("rst E_f3", E_f3, 0);
        chk("rst M_dm_req", M_dm_req, 0);
        chk("rst M_dm_w_en", M_dm_w_en, 0);
        chk("rst W_wb_en", W_wb_en, 0);
        chk("rst W_wb_data_sel", W_wb_data_sel, 0);
        chk("rst W_rd", W_rd, 0);
        chk("rst E_mdu_start", E_mdu_start, 0);
        step();
        rst = 1'b0;

        // Load-use, M/W forwarding priority, x0 handling.
        for (int i = 0; i < 10; i++) begin
            set_d(tbl[i].op, tbl[i].f3, tbl[i].f7, 1'b0, tbl[i].rd, tbl[i].rs1, tbl[i].rs2);
            #1;
            chk($sformatf("row%0d F_stall", i), F_stall, tbl[i].x_fst);
            chk($sformatf("row%0d D_stall", i), D_stall, tbl[i].x_fst);
            chk($sformatf("row%0d next_pc_sel", i), next_pc_sel, tbl[i].x_npc);
            chk($sformatf("row%0d E_op", i), E_op, tbl[i].x_eop);
            chk($sformatf("row%0d E_rs1_sel", i), E_rs1_sel, tbl[i].x_s1);
            chk($sformatf("row%0d E_rs2_sel", i), E_rs2_sel, tbl[i].x_s2);
            chk($sformatf("row%0d W_wb_en", i), W_wb_en, tbl[i].x_wb);
            chk($sformatf("row%0d M_dm_req", i), M_dm_req, tbl[i].x_req);
            chk($sformatf("row%0d D_rs1_sel", i), D_rs1_sel, tbl[i].x_drs1);
            step();
        end

        // sw held in M for three cycles of dm_ready=0.
        set_d(L_OP, 3'b000, 1'b0, 1'b0, 5'd10, 5'd0, 5'd0);
        step();
        set_d(L_STORE, 3'b010, 1'b0, 1'b0, 5'd0, 5'd2, 5'd6);
        step();
        set_d(L_OP, 3'b000, 1'b0, 1'b0, 5'd11, 5'd0, 5'd0);
        step();
        set_d(L_NOP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            dm_ready = 1'b0;
            #1;
            chk($sformatf("dmw%0d F_stall", c), F_stall, 1);
            chk($sformatf("dmw%0d D_stall", c), D_stall, 1);
            chk($sformatf("dmw%0d M_dm_w_en", c), M_dm_w_en, 4'b1111);
            chk($sformatf("dmw%0d M_dm_req", c), M_dm_req, 1);
            chk($sformatf("dmw%0d E_op", c), E_op, L_OP);
            chk($sformatf("dmw%0d W_wb_en", c), W_wb_en, (c == 0) ? 1 : 0);
            step();
        end
        dm_ready = 1'b1;
        #1;
        chk("dmdone F_stall", F_stall, 0);
        chk("dmdone M_dm_w_en", M_dm_w_en, 4'b1111);
        chk("dmdone W_wb_en", W_wb_en, 0);
        chk("dmdone E_op", E_op, L_OP);
        step();
        #1;
        chk("dmafter M_dm_w_en", M_dm_w_en, 4'b0000);
        chk("dmafter M_dm_req", M_dm_req, 0);
        chk("dmafter E_op", E_op, L_NOP);
        chk("dmafter W_wb_en", W_wb_en, 0);

        // Halfword store byte enables.
        set_d(L_STORE, 3'b001, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        set_d(L_NOP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        #1;
        chk("sh M_dm_w_en", M_dm_w_en, 4'b0011);
        step();
        step();

        // JAL held by dm_wait does not redirect until E is free.
        set_d(L_LOAD, 3'b010, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0);
        step();
        set_d(L_JAL, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0);
        step();
        set_d(L_NOP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        dm_ready = 1'b0;
        #1;
        chk("jalwait next_pc_sel", next_pc_sel, 1);
        chk("jalwait F_stall", F_stall, 1);
        chk("jalwait E_op", E_op, L_JAL);
        step();
        dm_ready = 1'b1;
        #1;
        chk("jal next_pc_sel", next_pc_sel, 0);
        chk("jal F_stall", F_stall, 0);
        chk("jal E_jb_op1_sel", E_jb_op1_sel, 1);
        chk("jal E_alu_op1_sel", E_alu_op1_sel, 1);
        step();
        set_d(L_BR, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2);
        #1;
        chk("jalflush E_op", E_op, L_NOP);
        chk("lw W_wb_data_sel", W_wb_data_sel, 1);
        chk("lw W_rd", W_rd, 3);
        chk("lw W_wb_en", W_wb_en, 1);
        step();

        // Taken branch while the fetch side also stalls: redirect wins.
        im_ready   = 1'b0;
        E_alu_bit0 = 1'b1;
        set_d(L_OP, 3'b000, 1'b0, 1'b0, 5'd4, 5'd1, 5'd1);
        #1;
        chk("beq next_pc_sel", next_pc_sel, 0);
        chk("beq F_stall", F_stall, 0);
        chk("beq D_stall", D_stall, 0);
        chk("beq E_rs1_sel", E_rs1_sel, 0);
        chk("beq E_rs2_sel", E_rs2_sel, 2);
        chk("beq E_alu_op2_sel", E_alu_op2_sel, 0);
        chk("beq D_rs1_sel", D_rs1_sel, 1);
        step();
        #1;
        chk("beqflush E_op", E_op, L_NOP);
        E_alu_bit0 = 1'b0;
        im_ready   = 1'b1;
        set_d(L_BR, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        im_ready = 1'b0;
        #1;
        chk("bnt next_pc_sel", next_pc_sel, 1);
        chk("bnt F_stall", F_stall, 1);
        step();
        im_ready = 1'b1;
        set_d(L_NOP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("imwait E_op", E_op, L_NOP);

        // MUL is single cycle in every build.
        set_d(L_OP, 3'b000, 1'b0, 1'b1, 5'd5, 5'd1, 5'd2);
        step();
        set_d(L_NOP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("mul E_mdu_start", E_mdu_start, 0);
        chk("mul F_stall", F_stall, 0);
        step();
        #1;
        chk("mul advanced E_op", E_op, L_NOP);

`ifdef RV32M_EN
        // Divide residency of 4, back-to-back start, then reset mid-divide.
        set_d(L_OP, 3'b100, 1'b0, 1'b1, 5'd5, 5'd1, 5'd2);
        step();
        set_d(L_OP, 3'b100, 1'b0, 1'b1, 5'd7, 5'd1, 5'd2);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("div c%0d E_mdu_start", c), E_mdu_start, (c == 0) ? 1 : 0);
            chk($sformatf("div c%0d F_stall", c), F_stall, (c < 3) ? 1 : 0);
            chk($sformatf("div c%0d E_op", c), E_op, L_OP);
            chk($sformatf("div c%0d E_f3", c), E_f3, 3'b100);
            step();
        end
        set_d(L_NOP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("div2 E_mdu_start", E_mdu_start, 1);
        chk("div2 F_stall", F_stall, 1);
        step();
        #1;
        chk("div2 c1 E_mdu_start", E_mdu_start, 0);
        chk("div2 c1 F_stall", F_stall, 1);
        step();
        rst = 1'b1;
        #1;
        chk("divrst next_pc_sel", next_pc_sel, 1);
        chk("divrst E_op", E_op, L_NOP);
        chk("divrst F_stall", F_stall, 0);
        chk("divrst E_mdu_start", E_mdu_start, 0);
        #2;
        rst = 1'b0;
        step();
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("postrst%0d E_mdu_start", c), E_mdu_start, 0);
            chk($sformatf("postrst%0d F_stall", c), F_stall, 0);
            step();
        end
`else
        // Without the M extension a divide encoding is an ordinary OP.
        set_d(L_OP, 3'b100, 1'b0, 1'b1, 5'd5, 5'd1, 5'd2);
        step();
        set_d(L_NOP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("nodiv E_mdu_start", E_mdu_start, 0);
        chk("nodiv F_stall", F_stall, 0);
        chk("nodiv E_op", E_op, L_OP);
        step();
        #1;
        chk("nodiv advanced E_op", E_op, L_NOP);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
